ahb_slave_mux_n: RTL and testbench
==================================

# ahb_slave_mux_n

Parametrised AHB-Lite data-phase response multiplexer for an N-slave bus segment. It sits between the address decoder and the master. It registers the one-hot slave select on each accepted address phase and steers that slave's HREADYOUT/HRESP/HRDATA/HEXOKAY back to the master. Unlike the fixed 4-port mux, it contains:
- an integrated default slave, which gives a two-cycle ERROR response on unmapped NONSEQ/SEQ transfers;
- a per-transfer wait-state watchdog with sticky timeout status.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports, legal 1..16
- DATA_WIDTH, 32, HRDATA width, legal 32 or 64
- TIMEOUT_CYCLES, 256, consecutive wait states before timeout is flagged; 0 disables the watchdog
- IDX_W, $clog2(NUM_SLAVES) (min 1), width of TIMEOUT_IDX

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HREADY  in  1  bus-level HREADY (this block's HREADYOUT after fabric feedback)
- HSEL  in  NUM_SLAVES  one-hot address-phase slave select from decoder
- HTRANS  in  2  address-phase transfer type
- HREADYOUT_S  in  NUM_SLAVES  per-slave HREADYOUT
- HRESP_S  in  NUM_SLAVES  per-slave HRESP
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- HEXOKAY_S  in  NUM_SLAVES  per-slave exclusive okay
- TIMEOUT_CLR  in  1  synchronous clear of TIMEOUT_STS
- HREADYOUT  out  1  muxed ready to master and slaves
- HRESP  out  1  muxed response
- HRDATA  out  DATA_WIDTH  muxed read data
- HEXOKAY  out  1  muxed exclusive okay
- TIMEOUT_PULSE  out  1  single-cycle timeout event
- TIMEOUT_STS  out  1  sticky timeout flag
- TIMEOUT_IDX  out  IDX_W  index of the slave that timed out (last event)

## Operation
- **Select register** sel_q[NUM_SLAVES-1:0]
  - Loaded with HSEL when HREADY=1; held otherwise.
  - Reset value is all zeros.
- **Muxing** (AND-OR; sel_q is one-hot by contract)
  - HREADYOUT = OR(sel_q[i] & HREADYOUT_S[i]) | ds_ready.
  - HRESP = OR(sel_q[i] & HRESP_S[i]) | ds_resp.
  - HRDATA = OR(sel_q[i] & HRDATA_S[i]).
  - HEXOKAY = OR(sel_q[i] & HEXOKAY_S[i]).
  - When sel_q = 0, HRDATA = 0 and HEXOKAY = 0; ready and response come from the default slave.
- **Default-slave FSM** (states DS_IDLE, DS_ERR1, DS_ERR2)
  - DS_IDLE: ds_ready=1, ds_resp=0. Go to DS_ERR1 when HREADY=1 & HSEL=0 & HTRANS[1]=1 (NONSEQ/SEQ). IDLE and BUSY with HSEL=0 stay in DS_IDLE and get a zero-wait OKAY.
  - DS_ERR1: ds_ready=0, ds_resp=1. Always go to DS_ERR2.
  - DS_ERR2: ds_ready=1, ds_resp=1. If HSEL=0 & HTRANS[1]=1 (back-to-back unmapped transfer), go to DS_ERR1; else go to DS_IDLE.
  - ds_ready and ds_resp are gated by sel_q=0. They are 0 whenever a real slave owns the data phase, except that ds_ready=1 in DS_IDLE applies only when sel_q=0.
- **Watchdog** (TIMEOUT_CYCLES>0)
  - wait_cnt increments each cycle with sel_q≠0 and HREADYOUT=0.
  - It clears to 0 on HREADYOUT=1 and saturates at TIMEOUT_CYCLES.
  - When wait_cnt transitions to TIMEOUT_CYCLES:
    - TIMEOUT_PULSE=1 for one cycle;
    - TIMEOUT_STS is set;
    - TIMEOUT_IDX is loaded with the encoded index of sel_q.
  - At most one pulse per transfer.
  - The watchdog is observational only; it does not alter the bus response.
  - If set and TIMEOUT_CLR occur in the same cycle, set wins.
- **Illegal input:** HSEL not one-hot gives an undefined OR-combination. This is flagged by assertion, not by the RTL.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=0, HRDATA=0, HEXOKAY=0, TIMEOUT_PULSE=0, TIMEOUT_STS=0, TIMEOUT_IDX=0, FSM=DS_IDLE, wait_cnt=0.
- **Datapath latency:**
  - The response mux is combinational from sel_q and the slave inputs: zero added cycles, no added wait states.
  - sel_q updates one cycle after the address phase is accepted.
- **Unmapped transfer:** the data phase takes exactly 2 cycles, (HREADYOUT,HRESP) = (0,1) then (1,1).
- **Watchdog:** TIMEOUT_PULSE is asserted in the cycle after the TIMEOUT_CYCLES-th consecutive low-HREADYOUT cycle.
- **Reset mid-transfer:** all state returns to reset values asynchronously; a pending ERROR sequence is abandoned.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HRESP_OKAY/HRESP_ERROR;
  - the default-slave state enum.
- One sub-module: ahb_default_slave (the FSM, outputs ds_ready/ds_resp). It is reusable on other bus segments.
- The watchdog and one-hot-to-index encoder stay inline.

## Test plan
- **Reset:** hold HRESETn=0 → HREADYOUT=1, HRESP=0, HRDATA=0, TIMEOUT_STS=0.
- **Read from slave 2 (N=4):** HSEL=4'b0100, HTRANS=NONSEQ, HRDATA_S slot2=32'hDEADBEEF → next cycle HRDATA=32'hDEADBEEF, HRESP=0.
- **Unmapped NONSEQ:** HSEL=0 → HREADYOUT/HRESP = 0/1 then 1/1.
- **Back-to-back unmapped transfers:** → ERR1,ERR2,ERR1,ERR2.
- **IDLE with HSEL=0:** → HREADYOUT=1, HRESP=0 with no wait state.
- **Watchdog:** TIMEOUT_CYCLES=8, slave 3 holds HREADYOUT_S=0 for 12 cycles → TIMEOUT_PULSE high exactly once in cycle 9, TIMEOUT_IDX=3, TIMEOUT_STS stays 1 until TIMEOUT_CLR. Repeat with a 7-cycle stall → no pulse.
- **Wait-state hold:** slave 1 inserts 3 waits while HSEL changes to slave 0 → sel_q holds slave 1 until HREADY=1; no data glitch from slave 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for bus-segment infrastructure blocks:
//   - HTRANS transfer-type encodings (IDLE / BUSY / NONSEQ / SEQ)
//   - HRESP encodings (OKAY / ERROR)
//   - state enum of the reusable default slave
// No ports; imported by ahb_default_slave and ahb_slave_mux_n.
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default slave: idle (zero-wait OKAY), then the two cycles of an ERROR
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dsState_t;

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Answers data phases that no real slave owns. Unmapped NONSEQ/SEQ transfers
// get the two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   i_hready        bus-level HREADY (address phase accepted when 1)
//   i_unmapped      address phase is an active transfer with no HSEL bit set
//   i_selNone       no real slave owns the current data phase
//   o_dsReady       default-slave HREADYOUT contribution
//   o_dsResp        default-slave HRESP contribution
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_hready,
    input  logic i_unmapped,
    input  logic i_selNone,
    output logic o_dsReady,
    output logic o_dsResp
);

    dsState_t r_state;
    dsState_t w_nextState;

    // State register; reset abandons any ERROR sequence in progress
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and outputs. Outputs are only driven while no real slave
    // owns the data phase so the top can OR them straight into the bus.
    // ERR2 is already a ready cycle, so a new unmapped transfer seen there
    // is being accepted and restarts the ERROR pair immediately.
    always_comb begin
        w_nextState = r_state;
        o_dsReady   = 1'b0;
        o_dsResp    = HRESP_OKAY;
        case (r_state)
            DS_IDLE: begin
                o_dsReady = i_selNone;
                if (i_hready && i_unmapped) begin
                    w_nextState = DS_ERR1;
                end
            end
            DS_ERR1: begin
                o_dsResp    = i_selNone ? HRESP_ERROR : HRESP_OKAY;
                w_nextState = DS_ERR2;
            end
            DS_ERR2: begin
                o_dsReady   = i_selNone;
                o_dsResp    = i_selNone ? HRESP_ERROR : HRESP_OKAY;
                w_nextState = i_unmapped ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                w_nextState = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux_n.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux_n
// AHB-Lite data-phase response multiplexer for an N-slave segment, with an
// integrated default slave and a per-transfer wait-state watchdog.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HREADY          bus HREADY (fed back from HREADYOUT by the fabric)
//   HSEL            one-hot address-phase slave select
//   HTRANS          address-phase transfer type
//   HREADYOUT_S, HRESP_S, HRDATA_S, HEXOKAY_S   per-slave responses
//   TIMEOUT_CLR     synchronous clear of TIMEOUT_STS
//   HREADYOUT, HRESP, HRDATA, HEXOKAY           muxed response to master
//   TIMEOUT_PULSE   one-cycle timeout event
//   TIMEOUT_STS     sticky timeout flag
//   TIMEOUT_IDX     index of the slave that last timed out
// ---------------------------------------------------------------------------
module ahb_slave_mux_n
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int IDX_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            HREADY,
    input  logic [NUM_SLAVES-1:0]           HSEL,
    input  logic [1:0]                      HTRANS,
    input  logic [NUM_SLAVES-1:0]           HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]           HRESP_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]           HEXOKAY_S,
    input  logic                            TIMEOUT_CLR,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [DATA_WIDTH-1:0]           HRDATA,
    output logic                            HEXOKAY,
    output logic                            TIMEOUT_PULSE,
    output logic                            TIMEOUT_STS,
    output logic [IDX_W-1:0]                TIMEOUT_IDX
);

    logic [NUM_SLAVES-1:0] r_sel;
    logic                  w_selNone;
    logic                  w_unmapped;
    logic                  w_dsReady;
    logic                  w_dsResp;
    logic                  w_slvReady;
    logic                  w_slvResp;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_exokay;
    logic [IDX_W-1:0]      w_selIdx;

    assign w_selNone  = ~|r_sel;
    assign w_unmapped = ~|HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    // Data-phase owner: captured on every accepted address phase and held
    // through wait states so a new HSEL cannot glitch the current response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sel <= '0;
        end else if (HREADY) begin
            r_sel <= HSEL;
        end
    end

    ahb_default_slave u_defaultSlave (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .i_hready   (HREADY),
        .i_unmapped (w_unmapped),
        .i_selNone  (w_selNone),
        .o_dsReady  (w_dsReady),
        .o_dsResp   (w_dsResp)
    );

    // AND-OR response mux; with r_sel all zero every term drops out and the
    // default slave alone supplies ready/response
    always_comb begin
        w_slvReady = 1'b0;
        w_slvResp  = 1'b0;
        w_rdata    = '0;
        w_exokay   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_slvReady = w_slvReady | (r_sel[i] & HREADYOUT_S[i]);
            w_slvResp  = w_slvResp  | (r_sel[i] & HRESP_S[i]);
            w_exokay   = w_exokay   | (r_sel[i] & HEXOKAY_S[i]);
            w_rdata    = w_rdata | ({DATA_WIDTH{r_sel[i]}} & HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign HREADYOUT = w_slvReady | w_dsReady;
    assign HRESP     = w_slvResp  | w_dsResp;
    assign HRDATA    = w_rdata;
    assign HEXOKAY   = w_exokay;

    // One-hot to index encoder for the watchdog's slave report
    always_comb begin
        w_selIdx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_selIdx = w_selIdx | IDX_W'(i);
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
            localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] r_waitCnt;
            logic             r_pulse;
            logic             r_sts;
            logic [IDX_W-1:0] r_idx;
            logic             w_stall;
            logic             w_hit;

            assign w_stall = ~w_selNone & ~HREADYOUT;
            // Only the step onto the saturation value fires, so a long
            // stall produces exactly one event per transfer
            assign w_hit   = w_stall && (r_waitCnt == CNT_PRE);

            // Consecutive wait-state counter for the transfer in progress
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    r_waitCnt <= '0;
                end else if (HREADYOUT) begin
                    r_waitCnt <= '0;
                end else if (w_stall && r_waitCnt != CNT_MAX) begin
                    r_waitCnt <= r_waitCnt + CNT_W'(1);
                end
            end

            // Timeout reporting; a new event beats a simultaneous clear so
            // software can never miss it
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    r_pulse <= 1'b0;
                    r_sts   <= 1'b0;
                    r_idx   <= '0;
                end else begin
                    r_pulse <= w_hit;
                    if (w_hit) begin
                        r_sts <= 1'b1;
                        r_idx <= w_selIdx;
                    end else if (TIMEOUT_CLR) begin
                        r_sts <= 1'b0;
                    end
                end
            end

            assign TIMEOUT_PULSE = r_pulse;
            assign TIMEOUT_STS   = r_sts;
            assign TIMEOUT_IDX   = r_idx;
        end else begin : g_noWatchdog
            assign TIMEOUT_PULSE = 1'b0;
            assign TIMEOUT_STS   = 1'b0;
            assign TIMEOUT_IDX   = '0;
        end
    endgenerate

    // The decoder must never select more than one slave on an accepted phase
    assert property (@(posedge HCLK) disable iff (!HRESETn) HREADY |-> $onehot0(HSEL));

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mux_n
// Bench for ahb_slave_mux_n (4 slaves, 32-bit data, 8-cycle watchdog).
// HREADY is looped back from HREADYOUT as the fabric would do. A
// transaction-level model tracks who owns the data phase, how many ERROR
// cycles remain and how long the current transfer has stalled; it is
// compared against the DUT on every falling edge. Directed sequences pin
// the model with literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mux_n;
    import ahb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TC = 8;
    localparam int IW = 2;

    logic               HCLK;
    logic               HRESETn;
    logic               HREADY;
    logic [NS-1:0]      HSEL;
    logic [1:0]         HTRANS;
    logic [NS-1:0]      HREADYOUT_S;
    logic [NS-1:0]      HRESP_S;
    logic [NS*DW-1:0]   HRDATA_S;
    logic [NS-1:0]      HEXOKAY_S;
    logic               TIMEOUT_CLR;
    logic               HREADYOUT;
    logic               HRESP;
    logic [DW-1:0]      HRDATA;
    logic               HEXOKAY;
    logic               TIMEOUT_PULSE;
    logic               TIMEOUT_STS;
    logic [IW-1:0]      TIMEOUT_IDX;

    int passCount  = 0;
    int checkCount = 0;

    // Model state: owner of the data phase (-1 = nobody), ERROR cycles still
    // to be shown, consecutive stall length, and the registered timeout view
    int mSel      = -1;
    int mErrLeft  = 0;
    int mStall    = 0;
    int mIdx      = 0;
    bit mPulse    = 1'b0;
    bit mSts      = 1'b0;

    ahb_slave_mux_n #(
        .NUM_SLAVES     (NS),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .HREADY        (HREADY),
        .HSEL          (HSEL),
        .HTRANS        (HTRANS),
        .HREADYOUT_S   (HREADYOUT_S),
        .HRESP_S       (HRESP_S),
        .HRDATA_S      (HRDATA_S),
        .HEXOKAY_S     (HEXOKAY_S),
        .TIMEOUT_CLR   (TIMEOUT_CLR),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .HEXOKAY       (HEXOKAY),
        .TIMEOUT_PULSE (TIMEOUT_PULSE),
        .TIMEOUT_STS   (TIMEOUT_STS),
        .TIMEOUT_IDX   (TIMEOUT_IDX)
    );

    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // One comparison: count it, and report it when it disagrees
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's address phase and slave responses just after the
    // rising edge; read data and exclusive-okay are random unless overridden
    task automatic applyStimulus(input logic [NS-1:0] hsel, input logic [1:0] htrans,
                                 input logic [NS-1:0] rdyS, input logic [NS-1:0] rspS,
                                 input logic clr);
        @(posedge HCLK);
        #1;
        HSEL        = hsel;
        HTRANS      = htrans;
        HREADYOUT_S = rdyS;
        HRESP_S     = rspS;
        TIMEOUT_CLR = clr;
        HEXOKAY_S   = NS'($urandom);
        for (int i = 0; i < NS; i++) begin
            HRDATA_S[i*DW +: DW] = $urandom;
        end
    endtask

    // Reference model and per-cycle compare, evaluated mid-cycle while the
    // inputs are stable; the state update then describes the coming edge
    always @(negedge HCLK) begin
        logic          expReady;
        logic          expResp;
        logic          expExok;
        logic [DW-1:0] expData;
        int            hselIdx;
        int            nextErr;
        bit            newPulse;

        if (!HRESETn) begin
            mSel     = -1;
            mErrLeft = 0;
            mStall   = 0;
            mIdx     = 0;
            mPulse   = 1'b0;
            mSts     = 1'b0;
        end

        if (mSel >= 0) begin
            expReady = HREADYOUT_S[mSel];
            expResp  = HRESP_S[mSel];
            expExok  = HEXOKAY_S[mSel];
            expData  = HRDATA_S[mSel*DW +: DW];
        end else begin
            expExok  = 1'b0;
            expData  = '0;
            expReady = (mErrLeft != 2);
            expResp  = (mErrLeft != 0);
        end

        checkOutput("HREADYOUT", HREADYOUT, expReady);
        checkOutput("HRESP", HRESP, expResp);
        checkOutput("HRDATA", HRDATA, expData);
        checkOutput("HEXOKAY", HEXOKAY, expExok);
        checkOutput("TIMEOUT_PULSE", TIMEOUT_PULSE, mPulse);
        checkOutput("TIMEOUT_STS", TIMEOUT_STS, mSts);
        checkOutput("TIMEOUT_IDX", TIMEOUT_IDX, 64'(mIdx));

        if (HRESETn) begin
            hselIdx = -1;
            for (int i = 0; i < NS; i++) begin
                if (HSEL[i]) hselIdx = i;
            end
            if (mErrLeft == 2) nextErr = 1;
            else if (expReady && HSEL == '0 && HTRANS[1]) nextErr = 2;
            else nextErr = 0;

            newPulse = 1'b0;
            if (expReady) begin
                mStall = 0;
            end else if (mSel >= 0 && mStall < TC) begin
                mStall++;
                if (mStall == TC) newPulse = 1'b1;
            end
            if (newPulse) begin
                mSts = 1'b1;
                mIdx = mSel;
            end else if (TIMEOUT_CLR) begin
                mSts = 1'b0;
            end
            mPulse = newPulse;
            if (expReady) mSel = hselIdx;
            mErrLeft = nextErr;
        end
    end

    // Hard time bound so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout: run exceeded its time limit, checks %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequences with literal expectations, then random traffic
    initial begin
        int stallLeft;
        stallLeft   = 0;
        HRESETn     = 1'b0;
        HSEL        = '0;
        HTRANS      = HTRANS_IDLE;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        HRDATA_S    = '0;
        HEXOKAY_S   = '0;
        TIMEOUT_CLR = 1'b0;

        $display("[TB] reset");
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("reset HREADYOUT", HREADYOUT, 1);
        checkOutput("reset HRESP", HRESP, 0);
        checkOutput("reset HRDATA", HRDATA, 0);
        checkOutput("reset TIMEOUT_STS", TIMEOUT_STS, 0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);

        $display("[TB] read slave 2");
        applyStimulus(4'b0100, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        HRDATA_S[2*DW +: DW] = 32'hDEADBEEF;
        @(negedge HCLK);
        checkOutput("read s2 HRDATA", HRDATA, 32'hDEADBEEF);
        checkOutput("read s2 HRESP", HRESP, 0);
        checkOutput("read s2 HREADYOUT", HREADYOUT, 1);

        $display("[TB] unmapped NONSEQ");
        applyStimulus(4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("unmapped c1 ready/resp", {HREADYOUT, HRESP}, 2'b01);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("unmapped c2 ready/resp", {HREADYOUT, HRESP}, 2'b11);
        applyStimulus(4'b0000, HTRANS_BUSY, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("idle after error ready/resp", {HREADYOUT, HRESP}, 2'b10);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("busy unmapped ready/resp", {HREADYOUT, HRESP}, 2'b10);

        $display("[TB] back-to-back unmapped");
        applyStimulus(4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        applyStimulus(4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("b2b ERR1a", {HREADYOUT, HRESP}, 2'b01);
        applyStimulus(4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("b2b ERR2a", {HREADYOUT, HRESP}, 2'b11);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("b2b ERR1b", {HREADYOUT, HRESP}, 2'b01);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("b2b ERR2b", {HREADYOUT, HRESP}, 2'b11);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("b2b idle", {HREADYOUT, HRESP}, 2'b10);

        $display("[TB] wait-state hold");
        applyStimulus(4'b0010, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(4'b0001, HTRANS_NONSEQ, (k <= 3) ? 4'b1101 : 4'b1111, 4'b0000, 1'b0);
            HRDATA_S[0*DW +: DW] = 32'hAAAA5555;
            HRDATA_S[1*DW +: DW] = 32'h11112222;
            @(negedge HCLK);
            checkOutput("hold HREADYOUT", HREADYOUT, (k == 4));
            checkOutput("hold HRDATA", HRDATA, 32'h11112222);
        end
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        HRDATA_S[0*DW +: DW] = 32'hAAAA5555;
        @(negedge HCLK);
        checkOutput("hold next HRDATA", HRDATA, 32'hAAAA5555);

        $display("[TB] watchdog 12-cycle stall");
        applyStimulus(4'b1000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(4'b0000, HTRANS_IDLE, 4'b0111, 4'b0000, 1'b0);
            @(negedge HCLK);
            checkOutput("wdog pulse", TIMEOUT_PULSE, (k == 9));
            checkOutput("wdog sts", TIMEOUT_STS, (k >= 9));
            if (k >= 9) checkOutput("wdog idx", TIMEOUT_IDX, 3);
        end
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("wdog release ready", HREADYOUT, 1);
        checkOutput("wdog sticky", TIMEOUT_STS, 1);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b1);
        @(negedge HCLK);
        checkOutput("wdog sts before clr edge", TIMEOUT_STS, 1);
        applyStimulus(4'b0000, HTRANS_IDLE, 4'b1111, 4'b0000, 1'b0);
        @(negedge HCLK);
        checkOutput("wdog sts cleared", TIMEOUT_STS, 0);

        $display("[TB] watchdog 7-cycle stall");
        applyStimulus(4'b1000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(4'b0000, HTRANS_IDLE, (k <= 7) ? 4'b0111 : 4'b1111, 4'b0000, 1'b0);
            @(negedge HCLK);
            checkOutput("short stall pulse", TIMEOUT_PULSE, 0);
            checkOutput("short stall sts", TIMEOUT_STS, 0);
        end

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            logic [NS-1:0] hsel;
            logic [NS-1:0] rdy;
            if ($urandom_range(0, 9) < 3) hsel = '0;
            else hsel = NS'(1) << $urandom_range(0, NS-1);
            if (stallLeft > 0) begin
                rdy = '0;
                stallLeft--;
            end else begin
                rdy = NS'($urandom) | NS'($urandom);
                if ($urandom_range(0, 39) == 0) stallLeft = $urandom_range(5, 12);
            end
            applyStimulus(hsel, 2'($urandom), rdy, NS'($urandom) & NS'($urandom),
                          $urandom_range(0, 15) == 0);
            if (c == 300) HRESETn = 1'b0;
            if (c == 302) HRESETn = 1'b1;
        end

        @(posedge HCLK);
        @(negedge HCLK);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
